// File: rtl/aemb2_ifetch.sv
// AEMB2 instruction fetch: PC, Wishbone-classic instruction bus master, fetch buffer and decoded-field view.
// Define AEMB2_IFETCH_PREFETCH_EN for a 2-entry prefetch FIFO; otherwise a single instruction register.
module aemb2_ifetch #(
  parameter int             IAW     = 16,
  parameter logic [IAW-1:0] RST_VEC = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ena_i,
  input  logic           fBRA_i,
  input  logic [IAW-1:0] rBPC_i,
  output logic [IAW-3:0] iwb_adr_o,
  output logic           iwb_stb_o,
  input  logic           iwb_ack_i,
  input  logic [31:0]    iwb_dat_i,
  output logic           rVAL_IF,
  output logic [IAW-1:0] rPC_IF,
  output logic [5:0]     rOPC_IF,
  output logic [4:0]     rRD_IF,
  output logic [4:0]     rRA_IF,
  output logic [4:0]     rRB_IF,
  output logic [10:0]    rALT_IF,
  output logic [15:0]    rIMM_IF
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  localparam logic [31:0]    NOP_WORD = 32'h8800_0000;
  localparam logic [IAW-1:0] RST_PC   = {RST_VEC[IAW-1:2], 2'b00};

  state_t         state_q;
  logic           stb_q;
  logic [IAW-3:0] adr_q;
  logic [IAW-1:0] fpc_q;
  logic [IAW-1:0] pc_last_q;
  logic [1:0]     cnt_q;
  logic [1:0]     cnt_nxt;
  logic           push;
  logic           pop;
  logic [IAW-1:0] fpc_inc;
  logic [IAW-1:0] bra_pc;
  logic [31:0]    head_word;
  logic [IAW-1:0] head_pc;
  logic [31:0]    cur_word;

  always_comb begin
    // data acked in DROP, or in the same cycle as a redirect, is discarded
    push    = stb_q & iwb_ack_i & (state_q == S_FETCH) & ~fBRA_i;
    pop     = (cnt_q != 2'd0) & ena_i & ~fBRA_i;
    cnt_nxt = cnt_q + {1'b0, push} - {1'b0, pop};
    fpc_inc = fpc_q + IAW'(4);
    bra_pc  = {rBPC_i[IAW-1:2], 2'b00};
  end

`ifdef AEMB2_IFETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
  logic [31:0]    word_q [2];
  logic [IAW-1:0] wpc_q  [2];
  logic           head_q;
  logic           tail_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else if (fBRA_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q[tail_q] <= iwb_dat_i;
      wpc_q[tail_q]  <= fpc_q;
    end
  end

  assign head_word = word_q[head_q];
  assign head_pc   = wpc_q[head_q];
`else
  localparam logic [1:0] DEPTH = 2'd1;
  logic [31:0]    word_q;
  logic [IAW-1:0] wpc_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q <= iwb_dat_i;
      wpc_q  <= fpc_q;
    end
  end

  assign head_word = word_q;
  assign head_pc   = wpc_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      stb_q   <= 1'b0;
      adr_q   <= RST_VEC[IAW-1:2];
      fpc_q   <= RST_PC;
      cnt_q   <= 2'd0;
    end else begin
      cnt_q <= fBRA_i ? 2'd0 : cnt_nxt;
      if (fBRA_i) begin
        fpc_q <= bra_pc;
        // an unacked request must keep its address until ack
        if (stb_q && !iwb_ack_i) begin
          state_q <= S_DROP;
        end else begin
          state_q <= S_FETCH;
          stb_q   <= 1'b1;
          adr_q   <= bra_pc[IAW-1:2];
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (!stb_q) begin
              stb_q <= 1'b1;
              adr_q <= fpc_q[IAW-1:2];
            end else if (iwb_ack_i) begin
              fpc_q <= fpc_inc;
              if (cnt_nxt < DEPTH) begin
                adr_q <= fpc_inc[IAW-1:2];
              end else begin
                stb_q   <= 1'b0;
                state_q <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (pop) begin
              state_q <= S_FETCH;
              stb_q   <= 1'b1;
              adr_q   <= fpc_q[IAW-1:2];
            end
          end
          S_DROP: begin
            if (iwb_ack_i) begin
              state_q <= S_FETCH;
              adr_q   <= fpc_q[IAW-1:2];
            end
          end
          default: begin
            state_q <= S_FETCH;
            stb_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              pc_last_q <= RST_PC;
    else if (cnt_q != 2'd0) pc_last_q <= head_pc;
  end

  assign iwb_stb_o = stb_q;
  assign iwb_adr_o = adr_q;
  assign rVAL_IF   = (cnt_q != 2'd0);
  assign rPC_IF    = rVAL_IF ? head_pc : pc_last_q;
  assign cur_word  = rVAL_IF ? head_word : NOP_WORD;
  assign rOPC_IF   = cur_word[31:26];
  assign rRD_IF    = cur_word[25:21];
  assign rRA_IF    = cur_word[20:16];
  assign rRB_IF    = cur_word[15:11];
  assign rALT_IF   = cur_word[10:0];
  assign rIMM_IF   = cur_word[15:0];

endmodule
